// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR interface: one read or write per request.
// Latency: R rises WAIT_STATES+1 Clk edges after the request-capture edge.
// Backpressure: four-phase handshake; R/DOUT/BUSY held in DONE until MEM_EN is seen low.
//
// Ports:
//   Clk, Reset_n     rising-edge clock, asynchronous active-low reset
//   MEM_EN, WE       request strobe (held until R) and write select, sampled at capture
//   ADDR, DIN        word address (from MAR) and write data (from MDR), sampled at capture
//   DOUT             read data, valid while R=1 on a read; holds until the next read completes
//   R, BUSY, ERR     transaction complete, in-flight indicator, address-range error
//
// Optional feature: define MEM_RESP_ADDR_CHECK_EN to flag captured addresses whose bits
// above AW are nonzero (ERR with R, write suppressed, read returns 16'hDEAD). When the
// macro is undefined ERR is tied low and addresses alias modulo 2**AW.
module mem_responder #(
    parameter int N           = 16,
    parameter int AW          = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         MEM_EN,
    input  logic         WE,
    input  logic [N-1:0] ADDR,
    input  logic [N-1:0] DIN,
    output logic [N-1:0] DOUT,
    output logic         R,
    output logic         BUSY,
    output logic         ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [N-1:0]    r_din;
    logic [N-1:0]    r_dout;
    logic            r_r;
    logic            r_busy;
    logic            r_err;
    logic [N-1:0]    r_mem [2**AW];

    logic            w_access;
    logic            w_addr_err;
    logic [N-1:0]    w_rd_dat;

    // The access happens on the WAIT edge where the countdown has reached zero.
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_RESP_ADDR_CHECK_EN
    localparam logic [N-1:0] DEAD_WORD = N'(16'hDEAD);

    logic [N-1:AW] r_addr_hi;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_addr_hi <= '0;
        end else if (r_state == S_IDLE && MEM_EN) begin
            r_addr_hi <= ADDR[N-1:AW];
        end
    end

    assign w_addr_err = |r_addr_hi;
    assign w_rd_dat   = w_addr_err ? DEAD_WORD : r_mem[r_addr];
`else
    // Upper address bits are deliberately dropped: addresses alias modulo 2**AW.
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^ADDR[N-1:AW];
    assign w_addr_err       = 1'b0;
    assign w_rd_dat         = r_mem[r_addr];
`endif

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. If MEM_EN drops during WAIT the access still completes and
    // DONE exits on the following edge, giving a single-cycle R pulse.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (MEM_EN)   w_state_nxt = S_WAIT;
            S_WAIT:  if (w_access) w_state_nxt = S_DONE;
            S_DONE:  if (!MEM_EN)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait countdown and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= 4'd0;
            r_addr <= '0;
            r_we   <= 1'b0;
            r_din  <= '0;
            r_dout <= '0;
            r_r    <= 1'b0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MEM_EN) begin
                        r_addr <= ADDR[AW-1:0];
                        r_we   <= WE;
                        r_din  <= DIN;
                        r_cnt  <= WS;
                        r_busy <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_access) begin
                        r_r   <= 1'b1;
                        r_err <= w_addr_err;
                        if (!r_we) begin
                            r_dout <= w_rd_dat;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!MEM_EN) begin
                        r_r    <= 1'b0;
                        r_busy <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; a reset before the access edge leaves the FSM in IDLE so no write occurs.
    always_ff @(posedge Clk) begin
        if (w_access && r_we && !w_addr_err) begin
            r_mem[r_addr] <= r_din;
        end
    end

    assign DOUT = r_dout;
    assign R    = r_r;
    assign BUSY = r_busy;
    assign ERR  = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (N=16, AW=10, WAIT_STATES=2).
// Inputs are driven and outputs sampled 1 time unit after each rising Clk edge.
// Expected values are hand-derived constants.
module tb_mem_responder;

    logic        Clk;
    logic        Reset_n;
    logic        MEM_EN;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        R;
    logic        BUSY;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    mem_responder #(.N(16), .AW(10), .WAIT_STATES(2)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .MEM_EN  (MEM_EN),
        .WE      (WE),
        .ADDR    (ADDR),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .R       (R),
        .BUSY    (BUSY),
        .ERR     (ERR)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a request and take the capture edge.
    task automatic start_req(input logic we, input logic [15:0] addr, input logic [15:0] din);
        MEM_EN = 1'b1;
        WE     = we;
        ADDR   = addr;
        DIN    = din;
        tick();
        chk("capture_busy", {15'd0, BUSY}, 16'd1);
        chk("capture_r",    {15'd0, R},    16'd0);
    endtask

    // Two wait edges with R low, then the access edge raises R.
    task automatic wait_done(input logic exp_err);
        tick();
        chk("wait1_r", {15'd0, R}, 16'd0);
        tick();
        chk("wait2_r", {15'd0, R}, 16'd0);
        tick();
        chk("done_r",    {15'd0, R},    16'd1);
        chk("done_busy", {15'd0, BUSY}, 16'd1);
        chk("done_err",  {15'd0, ERR},  {15'd0, exp_err});
    endtask

    task automatic end_req();
        MEM_EN = 1'b0;
        tick();
        chk("end_r",    {15'd0, R},    16'd0);
        chk("end_busy", {15'd0, BUSY}, 16'd0);
        chk("end_err",  {15'd0, ERR},  16'd0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] din, input logic exp_err);
        start_req(1'b1, addr, din);
        wait_done(exp_err);
        end_req();
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr,
                           input logic [15:0] exp, input logic exp_err);
        start_req(1'b0, addr, 16'h0000);
        wait_done(exp_err);
        chk(tag, DOUT, exp);
        end_req();
    endtask

    initial begin
        Reset_n = 1'b0;
        MEM_EN  = 1'b0;
        WE      = 1'b0;
        ADDR    = 16'h0000;
        DIN     = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_dout", DOUT, 16'h0000);
        chk("rst_r",    {15'd0, R},    16'd0);
        chk("rst_busy", {15'd0, BUSY}, 16'd0);
        chk("rst_err",  {15'd0, ERR},  16'd0);
        Reset_n = 1'b1;
        tick();

        // Write 0xBEEF to 0x0005, then read it back
        do_write(16'h0005, 16'hBEEF, 1'b0);
        do_read("rd5_beef", 16'h0005, 16'hBEEF, 1'b0);

        // Hold MEM_EN for 4 cycles after R: R and DOUT stable
        start_req(1'b0, 16'h0005, 16'h0000);
        wait_done(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_r",    {15'd0, R}, 16'd1);
            chk("hold_dout", DOUT, 16'hBEEF);
        end
        end_req();
        // Immediate re-request is captured on the next edge
        start_req(1'b1, 16'h0009, 16'hA5A5);
        wait_done(1'b0);
        chk("wr_keeps_dout", DOUT, 16'hBEEF);
        end_req();
        do_read("rd9_a5a5", 16'h0009, 16'hA5A5, 1'b0);

        // Reset mid-WAIT: outputs clear without a clock edge, write does not land
        start_req(1'b1, 16'h0005, 16'h1111);
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_r",    {15'd0, R},    16'd0);
        chk("mid_rst_busy", {15'd0, BUSY}, 16'd0);
        chk("mid_rst_dout", DOUT, 16'h0000);
        MEM_EN = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
        do_read("rd5_after_rst", 16'h0005, 16'hBEEF, 1'b0);

        // MEM_EN dropped right after capture: single-cycle R, write still lands
        start_req(1'b1, 16'h000A, 16'h0C0C);
        MEM_EN = 1'b0;
        tick();
        chk("drop_w1_r", {15'd0, R}, 16'd0);
        tick();
        chk("drop_w2_r", {15'd0, R}, 16'd0);
        tick();
        chk("drop_pulse_r", {15'd0, R}, 16'd1);
        tick();
        chk("drop_after_r",    {15'd0, R},    16'd0);
        chk("drop_after_busy", {15'd0, BUSY}, 16'd0);
        do_read("rdA_0c0c", 16'h000A, 16'h0C0C, 1'b0);

        // Inputs changed during WAIT are ignored
        start_req(1'b1, 16'h000B, 16'h1357);
        ADDR = 16'h0005;
        DIN  = 16'hFFFF;
        WE   = 1'b0;
        wait_done(1'b0);
        end_req();
        do_read("rdB_1357", 16'h000B, 16'h1357, 1'b0);
        do_read("rd5_untouched", 16'h0005, 16'hBEEF, 1'b0);

        // Address above 2**AW
`ifdef MEM_RESP_ADDR_CHECK_EN
        do_write(16'h0405, 16'h1234, 1'b1);
        do_read("rd405_dead", 16'h0405, 16'hDEAD, 1'b1);
        do_read("rd5_no_alias", 16'h0005, 16'hBEEF, 1'b0);
`else
        do_write(16'h0405, 16'h1234, 1'b0);
        do_read("rd5_alias", 16'h0005, 16'h1234, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
